// File: rtl/prog_inst_mem_pkg.sv
// Shared constants and FSM state type for the program instruction memory.
package prog_inst_mem_pkg;

    localparam int unsigned A_DEF     = 16;
    localparam int unsigned W_DEF     = 9;
    localparam int unsigned DEPTH_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_e;

endpackage

// File: rtl/prog_inst_mem_if.sv
// Load and fetch signal bundle between a program loader/fetcher and prog_inst_mem.
interface prog_inst_mem_if
    import prog_inst_mem_pkg::*;
#(
    parameter int unsigned A = A_DEF,
    parameter int unsigned W = W_DEF
);

    logic         LoadStart;
    logic         LoadValid;
    logic         LoadLast;
    logic [W-1:0] LoadData;
    logic         LoadReady;
    logic         LoadDone;
    logic         FetchEn;
    logic [A-1:0] InstAddress;
    logic [W-1:0] InstOut;
    logic         InstValid;
    logic         AddrFault;

    modport master (
        output LoadStart, LoadValid, LoadLast, LoadData, FetchEn, InstAddress,
        input  LoadReady, LoadDone, InstOut, InstValid, AddrFault
    );

    modport slave (
        input  LoadStart, LoadValid, LoadLast, LoadData, FetchEn, InstAddress,
        output LoadReady, LoadDone, InstOut, InstValid, AddrFault
    );

endinterface

// File: rtl/prog_inst_mem_inst_ram.sv
// DEPTH x W storage: one write port, one synchronous read port with read enable.
module inst_ram #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Read data only changes on an enabled read, so it doubles as the held output.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/prog_inst_mem.sv
// Loadable instruction memory: streams an image in, then serves 1-cycle-latency fetches.
module prog_inst_mem
    import prog_inst_mem_pkg::*;
#(
    parameter int unsigned A     = A_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic           Clk,
    input  logic           Reset,
    prog_inst_mem_if.slave bus
);

    localparam int unsigned RAM_AW = $clog2(DEPTH);

    state_e       state_q, state_d;
    logic [A-1:0] wptr_q,  wptr_d;
    logic [A:0]   cnt_q,   cnt_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;
    logic         zero_q,  zero_d;

    logic         ready;
    logic         accept;
    logic         fetch;
    logic         in_range;
    logic         last_slot;
    logic [W-1:0] rdata;

    always_comb begin
        ready     = (state_q == LOAD) && !bus.LoadStart;
        accept    = ready && bus.LoadValid;
        fetch     = (state_q == RUN) && bus.FetchEn && !bus.LoadStart;
        in_range  = {1'b0, bus.InstAddress} < cnt_q;
        last_slot = (wptr_q == A'(DEPTH - 1));

        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        if (bus.LoadStart) begin
            state_d = LOAD;
            wptr_d  = '0;
            cnt_d   = '0;
        end else if (accept) begin
            // Pointer parks on the final slot instead of wrapping.
            wptr_d = last_slot ? wptr_q : wptr_q + A'(1);
            cnt_d  = {1'b0, wptr_q} + (A+1)'(1);
            if (bus.LoadLast || last_slot) begin
                state_d = RUN;
            end
        end

        valid_d = fetch;
        fault_d = fetch && !in_range;
        zero_d  = fetch ? !in_range : zero_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            zero_q  <= zero_d;
        end
    end

    inst_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_inst_ram (
        .clk_i   (Clk),
        .we_i    (accept),
        .waddr_i (wptr_q[RAM_AW-1:0]),
        .wdata_i (bus.LoadData),
        .re_i    (fetch && in_range),
        .raddr_i (bus.InstAddress[RAM_AW-1:0]),
        .rdata_o (rdata)
    );

    // zero_q selects a forced-zero word after a faulting fetch and out of reset.
    assign bus.InstOut   = zero_q ? '0 : rdata;
    assign bus.InstValid = valid_q;
    assign bus.AddrFault = fault_q;
    assign bus.LoadReady = ready;
    assign bus.LoadDone  = (state_q == RUN);

endmodule

// File: tb/tb_prog_inst_mem.sv
// Scoreboard bench for prog_inst_mem: default-depth and DEPTH=4 instances.
module tb_prog_inst_mem;

    logic Clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    prog_inst_mem_if #(.A(16), .W(9)) ba ();
    prog_inst_mem_if #(.A(16), .W(9)) bb ();

    prog_inst_mem #(.A(16), .W(9), .DEPTH(1024)) dut_a (
        .Clk   (Clk),
        .Reset (rst_a),
        .bus   (ba)
    );

    prog_inst_mem #(.A(16), .W(9), .DEPTH(4)) dut_b (
        .Clk   (Clk),
        .Reset (rst_b),
        .bus   (bb)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         due;
        logic [8:0] data;
        logic       fault;
    } exp_t;

    exp_t sbq [2][$];

    logic       mv [2];
    logic [8:0] mo [2];
    logic       mf [2];
    assign mv[0] = ba.InstValid;
    assign mo[0] = ba.InstOut;
    assign mf[0] = ba.AddrFault;
    assign mv[1] = bb.InstValid;
    assign mo[1] = bb.InstOut;
    assign mf[1] = bb.AddrFault;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: a fetch expectation is due on exactly one cycle; valid must match it.
    always @(negedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            logic expv;
            exp_t e;
            expv = (sbq[d].size() > 0) && (sbq[d][0].due == cyc);
            if (mv[d] || expv) begin
                chk($sformatf("inst_valid_dut%0d", d), 32'(mv[d]), 32'(expv));
                if (expv) begin
                    e = sbq[d].pop_front();
                    if (mv[d]) begin
                        chk($sformatf("inst_out_dut%0d", d), 32'(mo[d]), 32'(e.data));
                        chk($sformatf("addr_fault_dut%0d", d), 32'(mf[d]), 32'(e.fault));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic fetch(input int d, input logic [15:0] addr, input logic [8:0] data,
                         input logic fault);
        if (d == 0) begin
            ba.FetchEn     = 1'b1;
            ba.InstAddress = addr;
        end else begin
            bb.FetchEn     = 1'b1;
            bb.InstAddress = addr;
        end
        sbq[d].push_back('{due: cyc + 1, data: data, fault: fault});
        tick();
    endtask

    logic [8:0] img [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        img = '{9'h011, 9'h022, 9'h033, 9'h000, 9'h000};
        {ba.LoadStart, ba.LoadValid, ba.LoadLast, ba.FetchEn} = '0;
        {bb.LoadStart, bb.LoadValid, bb.LoadLast, bb.FetchEn} = '0;
        ba.LoadData = '0; ba.InstAddress = '0;
        bb.LoadData = '0; bb.InstAddress = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        chk("rst_inst_out",   32'(ba.InstOut),   0);
        chk("rst_inst_valid", 32'(ba.InstValid), 0);
        chk("rst_addr_fault", 32'(ba.AddrFault), 0);
        chk("rst_load_ready", 32'(ba.LoadReady), 0);
        chk("rst_load_done",  32'(ba.LoadDone),  0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // Three-word image, LoadLast on the third.
        ba.LoadStart = 1'b1;
        tick();
        ba.LoadStart = 1'b0;
        ba.LoadValid = 1'b1;
        ba.LoadData  = 9'h011;
        settle();
        chk("ready_in_load", 32'(ba.LoadReady), 1);
        tick();
        ba.LoadData = 9'h022;
        tick();
        chk("done_mid_load", 32'(ba.LoadDone), 0);
        ba.LoadData = 9'h033;
        ba.LoadLast = 1'b1;
        tick();
        ba.LoadValid = 1'b0;
        ba.LoadLast  = 1'b0;
        settle();
        chk("done_after_last",  32'(ba.LoadDone),  1);
        chk("ready_after_last", 32'(ba.LoadReady), 0);

        fetch(0, 16'd0, 9'h011, 1'b0);
        fetch(0, 16'd1, 9'h022, 1'b0);
        fetch(0, 16'd2, 9'h033, 1'b0);
        fetch(0, 16'd3, 9'h000, 1'b1);
        fetch(0, 16'hFFFF, 9'h000, 1'b1);
        fetch(0, 16'h8001, 9'h000, 1'b1);
        fetch(0, 16'd2, 9'h033, 1'b0);
        ba.FetchEn = 1'b0;
        tick();
        chk("hold_valid", 32'(ba.InstValid), 0);
        chk("hold_out",   32'(ba.InstOut),   32'h033);
        chk("hold_fault", 32'(ba.AddrFault), 0);

        for (int i = 0; i < 5; i++) begin
            fetch(0, 16'(i), img[i], i >= 3);
        end
        fetch(0, 16'd2, 9'h033, 1'b0);
        ba.FetchEn = 1'b0;
        tick();

        // Reload from RUN; a fetch in the LoadStart cycle is not serviced.
        ba.LoadStart   = 1'b1;
        ba.FetchEn     = 1'b1;
        ba.InstAddress = 16'd0;
        tick();
        chk("no_fetch_on_loadstart", 32'(ba.InstValid), 0);
        chk("done_cleared_reload",   32'(ba.LoadDone),  0);
        ba.LoadValid = 1'b1;
        ba.LoadData  = 9'h155;
        settle();
        chk("ready_low_on_loadstart", 32'(ba.LoadReady), 0);
        tick();
        chk("fetch_ignored_in_load", 32'(ba.InstValid), 0);
        chk("out_held_in_load",      32'(ba.InstOut),   32'h033);
        ba.LoadStart = 1'b0;
        ba.FetchEn   = 1'b0;
        ba.LoadData  = 9'h1AA;
        ba.LoadLast  = 1'b1;
        tick();
        ba.LoadValid = 1'b0;
        ba.LoadLast  = 1'b0;
        settle();
        chk("done_single_word", 32'(ba.LoadDone), 1);
        fetch(0, 16'd0, 9'h1AA, 1'b0);
        fetch(0, 16'd1, 9'h000, 1'b1);
        ba.FetchEn = 1'b0;
        tick();

        // Reset in the middle of a load.
        ba.LoadStart = 1'b1;
        tick();
        ba.LoadStart = 1'b0;
        ba.LoadValid = 1'b1;
        ba.LoadData  = 9'h0AB;
        tick();
        ba.LoadData = 9'h0CD;
        tick();
        rst_a = 1'b1;
        settle();
        chk("midrst_ready", 32'(ba.LoadReady), 0);
        chk("midrst_done",  32'(ba.LoadDone),  0);
        chk("midrst_out",   32'(ba.InstOut),   0);
        ba.FetchEn     = 1'b1;
        ba.InstAddress = 16'd0;
        tick();
        chk("midrst_fetch_ignored", 32'(ba.InstValid), 0);
        rst_a = 1'b0;
        tick();
        settle();
        chk("postrst_valid", 32'(ba.InstValid), 0);
        chk("postrst_ready", 32'(ba.LoadReady), 0);
        chk("postrst_done",  32'(ba.LoadDone),  0);
        tick();
        chk("postrst_valid2", 32'(ba.InstValid), 0);
        ba.FetchEn   = 1'b0;
        ba.LoadValid = 1'b0;

        // DEPTH=4: a full image without LoadLast ends the load.
        bb.LoadStart = 1'b1;
        tick();
        bb.LoadStart = 1'b0;
        bb.LoadValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bb.LoadData = 9'h100 + 9'(i);
            settle();
            chk($sformatf("b_ready_word%0d", i), 32'(bb.LoadReady), 1);
            chk($sformatf("b_done_word%0d", i),  32'(bb.LoadDone),  0);
            tick();
        end
        bb.LoadData = 9'h1FF;
        settle();
        chk("b_done_full",  32'(bb.LoadDone),  1);
        chk("b_ready_full", 32'(bb.LoadReady), 0);
        tick();
        bb.LoadValid = 1'b0;
        fetch(1, 16'd3, 9'h103, 1'b0);
        fetch(1, 16'd0, 9'h100, 1'b0);
        fetch(1, 16'd4, 9'h000, 1'b1);
        fetch(1, 16'd1, 9'h101, 1'b0);
        bb.FetchEn = 1'b0;
        tick();
        tick();

        chk("sb_drain", 32'(sbq[0].size() + sbq[1].size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
